signal_gen: RTL and testbench



---
 rtl/signal_gen.sv | 120 ++++++++++++
 tb/tb_signal_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_gen.sv
// signal_gen: run-length symbol transmitter; each accepted bit becomes a paced run of symbols.
// Optional abort input enabled by defining SIGNAL_GEN_ABORT_EN.
module signal_gen #(
   parameter int unsigned CNT_W   = 10,
   parameter int unsigned RUN_LEN = 6,
   parameter int unsigned GAP_LEN = 1,
   parameter int unsigned SYM_DIV = 1,
   parameter int unsigned MODE    = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_bit_vld,
   input  logic i_bit_data,
`ifdef SIGNAL_GEN_ABORT_EN
   input  logic i_abort,
`endif
   output logic o_bit_rdy,
   output logic o_vld,
   output logic o_vld_data,
   output logic o_busy
);

   localparam int unsigned NSYM  = (MODE == 0) ? RUN_LEN + GAP_LEN : RUN_LEN;
   localparam int unsigned DIV_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

   state_e           state_q, state_d;
   logic             bit_q, bit_d;
   logic [CNT_W-1:0] sym_q, sym_d, sym_nxt_c;
   logic [DIV_W-1:0] div_q, div_d;
   logic             vld_q, vld_d;
   logic             data_q, data_d;
   logic             busy_q, busy_d;
   logic             abort_c, slot_end_c, last_sym_c, term_c, rdy_c, accept_c;

`ifdef SIGNAL_GEN_ABORT_EN
   assign abort_c = i_abort;
`else
   assign abort_c = 1'b0;
`endif

   // Terminal cycle: last clock of the final symbol slot of the current bit.
   assign slot_end_c = (div_q == DIV_W'(SYM_DIV - 1));
   assign last_sym_c = (sym_q == CNT_W'(NSYM - 1));
   assign term_c     = (state_q == ACTIVE) && slot_end_c && last_sym_c;
   assign sym_nxt_c  = sym_q + CNT_W'(1);

   assign rdy_c     = !i_rst && !abort_c && ((state_q == IDLE) || term_c);
   assign accept_c  = rdy_c && i_bit_vld;
   assign o_bit_rdy = rdy_c;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = ACTIVE;
         ACTIVE:  if (abort_c || (term_c && !accept_c)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slot/symbol sequencing and the registered strobe/data/busy values.
   always_comb begin
      bit_d  = bit_q;
      sym_d  = sym_q;
      div_d  = div_q;
      vld_d  = 1'b0;
      data_d = data_q;
      if (accept_c) begin
         bit_d  = i_bit_data;
         sym_d  = '0;
         div_d  = '0;
         vld_d  = 1'b1;
         data_d = i_bit_data;
      end else if ((state_q == ACTIVE) && !abort_c) begin
         if (slot_end_c) begin
            div_d = '0;
            if (!last_sym_c) begin
               sym_d  = sym_nxt_c;
               vld_d  = 1'b1;
               data_d = (sym_nxt_c < CNT_W'(RUN_LEN)) ? bit_q : !bit_q;
            end
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
      busy_d = (state_d == ACTIVE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bit_q  <= 1'b0;
         sym_q  <= '0;
         div_q  <= '0;
         vld_q  <= 1'b0;
         data_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         bit_q  <= bit_d;
         sym_q  <= sym_d;
         div_q  <= div_d;
         vld_q  <= vld_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   assign o_vld      = vld_q;
   assign o_vld_data = data_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_signal_gen.sv
// tb_signal_gen: two signal_gen instances (OWT div1, PWM div2) checked every cycle
// against a schedule-based model, plus literal checks of the documented waveforms.
module tb_signal_gen;

   localparam int NCYC = 4096;
   localparam int unsigned R0 = 4, G0 = 2, D0 = 1, M0 = 1;
   localparam int unsigned R1 = 3, G1 = 1, D1 = 2, M1 = 0;

   logic clk = 1'b0;
   always #5 clk = !clk;

   logic rst_i [2];
   logic vld_i [2];
   logic dat_i [2];
   logic abt_i [2];
   logic o_rdy [2];
   logic o_vld [2];
   logic o_dat [2];
   logic o_bsy [2];

   signal_gen #(.CNT_W(10), .RUN_LEN(R0), .GAP_LEN(G0), .SYM_DIV(D0), .MODE(M0)) u_dut0 (
      .i_clk(clk), .i_rst(rst_i[0]), .i_bit_vld(vld_i[0]), .i_bit_data(dat_i[0]),
`ifdef SIGNAL_GEN_ABORT_EN
      .i_abort(abt_i[0]),
`endif
      .o_bit_rdy(o_rdy[0]), .o_vld(o_vld[0]), .o_vld_data(o_dat[0]), .o_busy(o_bsy[0])
   );

   signal_gen #(.CNT_W(10), .RUN_LEN(R1), .GAP_LEN(G1), .SYM_DIV(D1), .MODE(M1)) u_dut1 (
      .i_clk(clk), .i_rst(rst_i[1]), .i_bit_vld(vld_i[1]), .i_bit_data(dat_i[1]),
`ifdef SIGNAL_GEN_ABORT_EN
      .i_abort(abt_i[1]),
`endif
      .o_bit_rdy(o_rdy[1]), .o_vld(o_vld[1]), .o_vld_data(o_dat[1]), .o_busy(o_bsy[1])
   );

   // Model parameters: symbols per bit, clocks per slot, run length.
   int nsym_m [2];
   int div_m  [2];
   int run_m  [2];

   // Model state: scheduled strobes and busy per cycle, derived from accept times.
   logic ev_vld [2][NCYC];
   logic ev_dat [2][NCYC];
   logic ev_bsy [2][NCYC];
   logic held_m [2];
   logic act_m  [2];
   int   term_m [2];
   logic acc_m  [2];

   logic obs_rdy [2][NCYC];
   logic obs_vld [2][NCYC];
   logic obs_dat [2][NCYC];
   logic obs_bsy [2][NCYC];

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   logic q0 [$];
   logic q1 [$];
   logic pend [2];
   logic pbit [2];

   task automatic chk(input string nm, input int d, input int c, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d got=%b want=%b", nm, d, c, act, exp);
      end
   endtask

   function automatic logic model_rdy(input int d);
      return !rst_i[d] && !abt_i[d] && (!act_m[d] || (cyc == term_m[d]));
   endfunction

   task automatic clear_future(input int d);
      for (int t = cyc + 1; t < cyc + 64; t++) begin
         ev_vld[d][t] = 1'b0;
         ev_bsy[d][t] = 1'b0;
      end
   endtask

   // One clock: compare this cycle's outputs, advance the model, cross the edge.
   task automatic step();
      logic rdy_m;
      #1;
      for (int d = 0; d < 2; d++) begin
         rdy_m = model_rdy(d);
         obs_rdy[d][cyc] = o_rdy[d];
         obs_vld[d][cyc] = o_vld[d];
         obs_dat[d][cyc] = o_dat[d];
         obs_bsy[d][cyc] = o_bsy[d];
         chk("rdy", d, cyc, o_rdy[d], rdy_m);
         if (cyc > 0) begin
            if (ev_vld[d][cyc]) held_m[d] = ev_dat[d][cyc];
            chk("vld", d, cyc, o_vld[d], ev_vld[d][cyc]);
            chk("data", d, cyc, o_dat[d], held_m[d]);
            chk("busy", d, cyc, o_bsy[d], ev_bsy[d][cyc]);
         end
         acc_m[d] = 1'b0;
         if (rst_i[d]) begin
            clear_future(d);
            held_m[d] = 1'b0;
            act_m[d]  = 1'b0;
         end else if (abt_i[d] && act_m[d]) begin
            clear_future(d);
            act_m[d] = 1'b0;
         end else if (rdy_m && vld_i[d]) begin
            acc_m[d] = 1'b1;
            for (int k = 0; k < nsym_m[d]; k++) begin
               ev_vld[d][cyc + 1 + k * div_m[d]] = 1'b1;
               ev_dat[d][cyc + 1 + k * div_m[d]] = (k < run_m[d]) ? dat_i[d] : !dat_i[d];
            end
            for (int t = cyc + 1; t <= cyc + nsym_m[d] * div_m[d]; t++) ev_bsy[d][t] = 1'b1;
            act_m[d]  = 1'b1;
            term_m[d] = cyc + nsym_m[d] * div_m[d];
         end else if (act_m[d] && (cyc == term_m[d])) begin
            act_m[d] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Source side: each queue holds bits offered until accepted.
   task automatic step_src();
      vld_i[0] = (q0.size() > 0);
      dat_i[0] = 1'b0;
      if (q0.size() > 0) dat_i[0] = q0[0];
      vld_i[1] = (q1.size() > 0);
      dat_i[1] = 1'b0;
      if (q1.size() > 0) dat_i[1] = q1[0];
      step();
      if (acc_m[0] && (q0.size() > 0)) void'(q0.pop_front());
      if (acc_m[1] && (q1.size() > 0)) void'(q1.pop_front());
   endtask

   initial begin
      int b;
      nsym_m[0] = int'((M0 == 0) ? R0 + G0 : R0);
      nsym_m[1] = int'((M1 == 0) ? R1 + G1 : R1);
      div_m[0]  = int'(D0);
      div_m[1]  = int'(D1);
      run_m[0]  = int'(R0);
      run_m[1]  = int'(R1);
      for (int d = 0; d < 2; d++) begin
         for (int t = 0; t < NCYC; t++) begin
            ev_vld[d][t] = 1'b0;
            ev_dat[d][t] = 1'b0;
            ev_bsy[d][t] = 1'b0;
         end
         held_m[d] = 1'b0;
         act_m[d]  = 1'b0;
         term_m[d] = 0;
         acc_m[d]  = 1'b0;
         pend[d]   = 1'b0;
         pbit[d]   = 1'b0;
         rst_i[d]  = 1'b1;
         vld_i[d]  = 1'b0;
         dat_i[d]  = 1'b0;
         abt_i[d]  = 1'b0;
      end

      step_src();
      step_src();
      rst_i[0] = 1'b0;
      rst_i[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("lit_rst_vld", d, 1, obs_vld[d][1], 1'b0);
         chk("lit_rst_data", d, 1, obs_dat[d][1], 1'b0);
         chk("lit_rst_busy", d, 1, obs_bsy[d][1], 1'b0);
      end

      // OWT bits 1,0 back-to-back on dut0; PWM single bit 1 on dut1.
      b = cyc;
      q0.push_back(1'b1);
      q0.push_back(1'b0);
      q1.push_back(1'b1);
      repeat (12) step_src();
      chk("lit1_rdy_a0", 0, b, obs_rdy[0][b], 1'b1);
      chk("lit1_rdy_a3", 0, b + 3, obs_rdy[0][b + 3], 1'b0);
      chk("lit1_rdy_a4", 0, b + 4, obs_rdy[0][b + 4], 1'b1);
      for (int k = 1; k <= 8; k++) begin
         chk("lit1_vld", 0, b + k, obs_vld[0][b + k], 1'b1);
         chk("lit1_data", 0, b + k, obs_dat[0][b + k], (k <= 4) ? 1'b1 : 1'b0);
         chk("lit2_vld", 1, b + k, obs_vld[1][b + k], (k % 2 == 1) ? 1'b1 : 1'b0);
         if (k % 2 == 1) chk("lit2_data", 1, b + k, obs_dat[1][b + k], (k < 7) ? 1'b1 : 1'b0);
      end
      chk("lit1_vld_end", 0, b + 9, obs_vld[0][b + 9], 1'b0);
      chk("lit1_busy8", 0, b + 8, obs_bsy[0][b + 8], 1'b1);
      chk("lit1_busy9", 0, b + 9, obs_bsy[0][b + 9], 1'b0);
      chk("lit1_busy10", 0, b + 10, obs_bsy[0][b + 10], 1'b0);
      chk("lit2_rdy7", 1, b + 7, obs_rdy[1][b + 7], 1'b0);
      chk("lit2_rdy8", 1, b + 8, obs_rdy[1][b + 8], 1'b1);
      chk("lit2_busy8", 1, b + 8, obs_bsy[1][b + 8], 1'b1);
      chk("lit2_busy9", 1, b + 9, obs_bsy[1][b + 9], 1'b0);

      // Reset two cycles into a run, then a fresh bit.
      b = cyc;
      q0.push_back(1'b1);
      step_src();
      step_src();
      rst_i[0] = 1'b1;
      step_src();
      rst_i[0] = 1'b0;
      q0.delete();
      q0.push_back(1'b1);
      repeat (10) step_src();
      chk("lit3_vld1", 0, b + 1, obs_vld[0][b + 1], 1'b1);
      chk("lit3_rdy2", 0, b + 2, obs_rdy[0][b + 2], 1'b0);
      chk("lit3_vld3", 0, b + 3, obs_vld[0][b + 3], 1'b0);
      chk("lit3_data3", 0, b + 3, obs_dat[0][b + 3], 1'b0);
      chk("lit3_busy3", 0, b + 3, obs_bsy[0][b + 3], 1'b0);
      chk("lit3_rdy3", 0, b + 3, obs_rdy[0][b + 3], 1'b1);
      chk("lit3_vld4", 0, b + 4, obs_vld[0][b + 4], 1'b1);
      chk("lit3_data4", 0, b + 4, obs_dat[0][b + 4], 1'b1);

`ifdef SIGNAL_GEN_ABORT_EN
      // Abort two cycles into a run, then abort held during an idle offer.
      b = cyc;
      q0.push_back(1'b1);
      step_src();
      step_src();
      abt_i[0] = 1'b1;
      step_src();
      abt_i[0] = 1'b0;
      repeat (3) step_src();
      chk("lit4_busy3", 0, b + 3, obs_bsy[0][b + 3], 1'b0);
      chk("lit4_vld3", 0, b + 3, obs_vld[0][b + 3], 1'b0);
      chk("lit4_data3", 0, b + 3, obs_dat[0][b + 3], 1'b1);
      chk("lit4_vld4", 0, b + 4, obs_vld[0][b + 4], 1'b0);
      b = cyc;
      abt_i[0] = 1'b1;
      q0.push_back(1'b0);
      step_src();
      step_src();
      abt_i[0] = 1'b0;
      repeat (8) step_src();
      chk("lit5_rdy0", 0, b, obs_rdy[0][b], 1'b0);
      chk("lit5_rdy1", 0, b + 1, obs_rdy[0][b + 1], 1'b0);
      chk("lit5_busy2", 0, b + 2, obs_bsy[0][b + 2], 1'b0);
      chk("lit5_busy3", 0, b + 3, obs_bsy[0][b + 3], 1'b1);
`endif

      // Random traffic: held bits, data toggling while not ready, rare resets/aborts.
      for (int i = 0; i < 3000; i++) begin
         for (int d = 0; d < 2; d++) begin
            rst_i[d] = ($urandom_range(0, 199) == 0);
`ifdef SIGNAL_GEN_ABORT_EN
            abt_i[d] = ($urandom_range(0, 59) == 0);
`endif
            if (!pend[d] && ($urandom_range(0, 3) != 0)) begin
               pend[d] = 1'b1;
               pbit[d] = 1'($urandom_range(0, 1));
            end
            vld_i[d] = pend[d];
            dat_i[d] = pbit[d];
            if (!model_rdy(d)) begin
               vld_i[d] = pend[d] | 1'($urandom_range(0, 1));
               dat_i[d] = 1'($urandom_range(0, 1));
            end
         end
         step();
         for (int d = 0; d < 2; d++) if (acc_m[d]) pend[d] = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
